// File: rtl/adder_if.sv
// Operand/result bundle for the 32-bit CLA adder.
// The master drives operands; the slave returns the registered result.
interface adder_if;
    logic        sub;
    logic [31:0] x;
    logic [31:0] y;
    logic        cout;
    logic [31:0] s;

    modport master (
        output sub,
        output x,
        output y,
        input  cout,
        input  s
    );

    modport slave (
        input  sub,
        input  x,
        input  y,
        output cout,
        output s
    );
endinterface

// File: rtl/adder.sv
// 32-bit carry-lookahead add/subtract core with a registered result.
// Two-level lookahead: 4-bit blocks under one 8-way group unit.
module adder (
    input  logic   clk,
    input  logic   rst,
    adder_if.slave bus
);

    logic        c0;
    logic [31:0] yp;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] r;
    logic [7:0]  bg;
    logic [7:0]  bp;
    logic [8:0]  bc;
    logic        term;
    logic        acc;

    assign c0 = bus.sub;
    assign yp = bus.y ^ {32{bus.sub}};
    assign g  = bus.x & yp;
    assign p  = bus.x ^ yp;

    for (genvar b = 0; b < 8; b++) begin : g_blk
        localparam int B = 4 * b;
        logic [3:0] gl;
        logic [3:0] pl;
        logic [3:0] cl;

        assign gl = g[B +: 4];
        assign pl = p[B +: 4];

        assign bp[b] = &pl;
        assign bg[b] = gl[3]
                     | (pl[3] & gl[2])
                     | (pl[3] & pl[2] & gl[1])
                     | (pl[3] & pl[2] & pl[1] & gl[0]);

        // In-block carries are flattened so no bit waits on its neighbour.
        assign cl[0] = bc[b];
        assign cl[1] = gl[0] | (pl[0] & bc[b]);
        assign cl[2] = gl[1] | (pl[1] & gl[0])
                     | (pl[1] & pl[0] & bc[b]);
        assign cl[3] = gl[2] | (pl[2] & gl[1])
                     | (pl[2] & pl[1] & gl[0])
                     | (pl[2] & pl[1] & pl[0] & bc[b]);

        assign r[B +: 4] = pl ^ cl;
    end

    // Each block carry-in is a sum of products of c0 and group G/P.
    always_comb begin
        term = 1'b0;
        acc  = 1'b0;
        bc   = '0;
        bc[0] = c0;
        for (int k = 1; k <= 8; k++) begin
            term = c0;
            for (int m = 0; m < k; m++) begin
                term = term & bp[m];
            end
            acc = term;
            for (int j = 0; j < k; j++) begin
                term = bg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & bp[m];
                end
                acc = acc | term;
            end
            bc[k] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cout <= 1'b0;
            bus.s    <= '0;
        end else begin
            bus.cout <= bc[8];
            bus.s    <= r;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Randomized bench for the CLA adder against an arithmetic model,
// with fixed vectors that pin known results.
module tb_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adder_if bus ();

    adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic        lit_en  = 1'b0;
    logic [32:0] lit_val = '0;

    logic        chk_en  = 1'b0;
    logic        chk_lit = 1'b0;
    logic [32:0] exp_m   = '0;
    logic [32:0] exp_l   = '0;

    function automatic logic [32:0] golden(
        input logic        r,
        input logic        sb,
        input logic [31:0] a,
        input logic [31:0] b
    );
        if (r) return 33'h0;
        if (sb) return {a >= b, a - b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        exp_m   <= golden(rst, bus.sub, bus.x, bus.y);
        chk_lit <= lit_en;
        exp_l   <= lit_val;
        chk_en  <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({bus.cout, bus.s} === exp_m)
                passed++;
            else
                $display("FAIL model t=%0t got %h required %h",
                         $time, {bus.cout, bus.s}, exp_m);
            if (chk_lit) begin
                checks++;
                if ({bus.cout, bus.s} === exp_l)
                    passed++;
                else
                    $display("FAIL literal t=%0t got %h required %h",
                             $time, {bus.cout, bus.s}, exp_l);
            end
        end
    end

    task automatic step(
        input logic        r,
        input logic        sb,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        le,
        input logic [32:0] lv
    );
        @(negedge clk);
        rst     = r;
        bus.sub = sb;
        bus.x   = a;
        bus.y   = b;
        lit_en  = le;
        lit_val = lv;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sb;

        rst     = 1'b1;
        bus.sub = 1'b0;
        bus.x   = 32'hFFFFFFFF;
        bus.y   = 32'h00000001;
        lit_en  = 1'b1;
        lit_val = 33'h0;

        step(1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, 33'h0);
        step(1'b0, 1'b0, 32'h56745675, 32'h54546576,
             1'b1, 33'h0_AAC8BBEB);
        step(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001,
             1'b1, 33'h1_00000000);
        step(1'b0, 1'b0, 32'h92384923, 32'h00000000,
             1'b1, 33'h0_92384923);
        step(1'b0, 1'b1, 32'hAB674594, 32'hAC784387,
             1'b1, 33'h0_FEEF020D);
        step(1'b0, 1'b1, 32'h00000005, 32'h00000005,
             1'b1, 33'h1_00000000);
        step(1'b0, 1'b1, 32'h00000000, 32'h00000001,
             1'b1, 33'h0_FFFFFFFF);
        step(1'b0, 1'b0, 32'h0FFFFFFF, 32'h00000001,
             1'b1, 33'h0_10000000);
        step(1'b0, 1'b0, 32'h000FFFFF, 32'h00000001,
             1'b1, 33'h0_00100000);
        step(1'b0, 1'b1, 32'h10000000, 32'h00000001,
             1'b1, 33'h1_0FFFFFFF);

        for (int i = 0; i < 300; i++) begin
            sb = i[0];
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 0) begin
                a = 32'hFFFFFFFF >> $urandom_range(0, 31);
                b = sb ? 32'hFFFFFFFF : 32'h1;
            end else if (i % 7 == 0) begin
                b = a;
            end
            if (i == 150)
                step(1'b1, sb, a, b, 1'b1, 33'h0);
            else
                step(1'b0, sb, a, b, 1'b0, 33'h0);
        end

        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 33'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adder.md
# adder

32-bit two-mode integer adder/subtractor built on a carry-lookahead (CLA) structure, used as the arithmetic core of the RISC-V datapath ALU. It computes x+y or x−y, with an explicit carry-out, and presents the result from an output register one clock after the operands are sampled. There is no overflow flag; the surrounding ALU derives signed overflow itself if it needs it.

## Interface

One clock; reset is synchronous and active-high (clk, rst).

No parameters; the width is fixed at 32 bits.

- clk  input  1  rising-edge clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- sub  input  1  operation select: 0 = add, 1 = subtract
- x  input  32  operand A
- y  input  32  operand B
- cout  output  1  registered carry-out of bit 31
- s  output  32  registered sum/difference

## Operation

- Internal operand: y' = y XOR {32{sub}}. Carry-in c0 = sub.
- Combinational result: {c32, r[31:0]} = x + y' + c0, a 33-bit result.
  - Add (sub=0): {cout,s} = x + y, exactly.
  - Subtract (sub=1): s = (x − y) mod 2^32, two's complement.
  - In subtract mode cout = 1 when x ≥ y unsigned (no borrow) and 0 when x < y (borrow).
- Carry structure:
  - 4-bit CLA blocks, each with generate g_i = x_i & y'_i and propagate p_i = x_i ^ y'_i.
  - Each block produces group G/P.
  - A second-level lookahead unit computes the eight block carry-ins from c0 and the group G/P.
  - Sum bit s_i = p_i ^ c_i.
  - No ripple chain longer than one 4-bit block.
- Signed and unsigned interpretations share the same bits; the block makes no distinction.
- No overflow flag is produced. Signed overflow is left to the ALU.

## Timing

- Rising edge with rst=1: s ← 0x00000000, cout ← 0. rst overrides all other inputs.
- Rising edge with rst=0: {cout,s} ← combinational result of the current sub, x and y.
- Latency: exactly 1 cycle from operand sampling to valid output.
- Throughput: one operation per cycle; there is no handshake and no enable.
- Operand changes between edges have no effect until the next edge.
- Outputs are glitch-free, driven only by flops.
- Reset mid-stream: the result that would have been captured on the reset edge is discarded. The next non-reset edge captures fresh operands normally.
- After reset release, the first valid result appears after the first non-reset rising edge.
- The combinational path x/y/sub → register D must close timing within one clock period.

## Test plan

- Reset: assert rst for 2 cycles with x=0xFFFFFFFF, y=1, sub=0 -> s=0x00000000, cout=0 on each reset edge.
- Add, no carry: sub=0, x=0x56745675, y=0x54546576 -> one edge later s=0xAAC8BBEB, cout=0.
- Add with wrap-around: sub=0, x=0xFFFFFFFF, y=0x00000001 -> s=0x00000000, cout=1. Also x=0x92384923, y=0 -> s=0x92384923, cout=0.
- Subtract with borrow: sub=1, x=0xAB674594, y=0xAC784387 -> s=0xFEEF020D, cout=0.
- Subtract, no borrow, and zero result:
  - sub=1, x=y=0x00000005 -> s=0x00000000, cout=1.
  - sub=1, x=0, y=1 -> s=0xFFFFFFFF, cout=0.
- Back-to-back plus randomized checks:
  - Change operands every cycle, alternating sub. Each output must match the golden {x+y} or {x−y mod 2^32, x≥y} of the previous cycle.
  - Include carry chains that cross every 4-bit block boundary, e.g. x=0x0FFFFFFF, y=1.
  - Assert rst for one cycle mid-stream -> outputs zero for that cycle, then resume with the following operands.
